// File: rtl/button_board_rx_db.sv
// Button-board receiver: direct lines plus one binary-encoded button group.
// Each channel is synchronised, debounced and turned into press/release events.
// Events are buffered in per-channel pending bits and drained one per handshake.
//
// Handshake: an event transfers on a rising clk edge where ev_valid && ev_ready.
// ev_valid, ev_idx and ev_press are registered, and stay stable while
// ev_valid && !ev_ready. ev_ready never reaches ev_valid combinationally.
module button_board_rx_db #(
    parameter int N_DIRECT        = 4,
    parameter int ENC_W           = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int N_OUT = N_DIRECT + 2**ENC_W,
    localparam int IDX_W = $clog2(N_OUT),
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_DIRECT+ENC_W:0]     b_in,
    output logic [N_OUT-1:0]            b_level,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [IDX_W-1:0]            ev_idx,
    output logic                        ev_press,
    output logic                        overflow,
    input  logic                        ovf_clr
);

    localparam int MSB = N_DIRECT + ENC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [ENC_W-1:0] field;
    logic [N_OUT-1:0] raw;
    logic [N_OUT-1:0] sync1;
    logic [N_OUT-1:0] sync2;
    logic [CNT_W-1:0] cnt [N_OUT];
    logic [N_OUT-1:0] acc;
    logic [N_OUT-1:0] set_press;
    logic [N_OUT-1:0] set_rel;
    logic [N_OUT-1:0] pend_press;
    logic [N_OUT-1:0] pend_rel;
    logic [N_OUT-1:0] clr_press;
    logic [N_OUT-1:0] clr_rel;
    logic             found_p;
    logic             found_r;
    logic [IDX_W-1:0] idx_p;
    logic [IDX_W-1:0] idx_r;
    logic             load;
    logic             ovf_set;

    assign field = b_in[MSB-1:N_DIRECT];

    // Map the raw board onto channels: direct lines first, then one channel per code.
    always_comb begin
        raw = '0;
        raw[N_DIRECT-1:0] = b_in[N_DIRECT-1:0];
        for (int k = 0; k < 2**ENC_W; k++) begin
            raw[N_DIRECT+k] = b_in[MSB] && (field == ENC_W'(k));
        end
    end

    // Two-flop synchroniser per channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A channel is accepted when it has differed from its level for the full count.
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            acc[i] = (sync2[i] != b_level[i]) && (cnt[i] == CNT_MAX);
        end
        set_press = acc & sync2;
        set_rel   = acc & ~sync2;
    end

    // Debounce counters: any return to the current level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
            b_level <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (sync2[i] == b_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    b_level[i] <= sync2[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Pick the next event: lowest pending press, else lowest pending release.
    always_comb begin
        load    = !ev_valid || ev_ready;
        found_p = 1'b0;
        found_r = 1'b0;
        idx_p   = '0;
        idx_r   = '0;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if (pend_press[i]) begin
                found_p = 1'b1;
                idx_p   = IDX_W'(i);
            end
            if (pend_rel[i]) begin
                found_r = 1'b1;
                idx_r   = IDX_W'(i);
            end
        end
        clr_press = '0;
        clr_rel   = '0;
        for (int i = 0; i < N_OUT; i++) begin
            clr_press[i] = load && found_p && (idx_p == IDX_W'(i));
            clr_rel[i]   = load && !found_p && found_r && (idx_r == IDX_W'(i));
        end
        // Re-setting a bit that stays pending means an event is lost.
        ovf_set = |((set_press & pend_press & ~clr_press) |
                    (set_rel & pend_rel & ~clr_rel));
    end

    // Pending masks, output event register and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_press <= '0;
            pend_rel   <= '0;
            ev_valid   <= 1'b0;
            ev_idx     <= '0;
            ev_press   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | set_press;
            pend_rel   <= (pend_rel & ~clr_rel) | set_rel;
            if (load) begin
                if (found_p) begin
                    ev_valid <= 1'b1;
                    ev_idx   <= idx_p;
                    ev_press <= 1'b1;
                end else if (found_r) begin
                    ev_valid <= 1'b1;
                    ev_idx   <= idx_r;
                    ev_press <= 1'b0;
                end else begin
                    ev_valid <= 1'b0;
                end
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_board_rx_db.sv
// Bench for button_board_rx_db with DEBOUNCE_CYCLES=4 (12 channels).
// Stimulus pushes expected {press, idx} events; the monitor pops on each handshake.
module tb_button_board_rx_db;

    localparam int N_DIRECT = 4;
    localparam int ENC_W    = 3;
    localparam int DEB      = 4;
    localparam int N_OUT    = 12;
    localparam int IDX_W    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       b_in;
    logic [N_OUT-1:0] b_level;
    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_idx;
    logic             ev_press;
    logic             overflow;
    logic             ovf_clr;

    logic [IDX_W:0] exp_q[$];
    logic [IDX_W:0] mon_e;
    int n_checks = 0;
    int n_pass   = 0;

    // clock / reset
    always #5 clk = ~clk;

    button_board_rx_db #(
        .N_DIRECT(N_DIRECT),
        .ENC_W(ENC_W),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .b_in(b_in),
        .b_level(b_level),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_idx(ev_idx),
        .ev_press(ev_press),
        .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic press, input int idx);
        exp_q.push_back({press, IDX_W'(idx)});
    endtask

    // scoreboard monitor: compare each accepted event against the queue
    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got idx %0d press %0d, expected none",
                         ev_idx, ev_press);
            end else begin
                mon_e = exp_q.pop_front();
                check("event", {ev_press, ev_idx}, mon_e);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        b_in     = 8'h00;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        tick(3);
        check("rst_level", b_level, 0);
        check("rst_valid", ev_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_idx", ev_idx, 0);
        check("rst_press", ev_press, 0);
        reset = 1'b0;

        // latency: bit0 press
        ev_ready = 1'b1;
        b_in = 8'h01;
        expect_ev(1'b1, 0);
        tick(5);
        check("t1_level_e5", b_level, 0);
        tick(1);
        check("t1_level_e6", b_level, 12'h001);
        check("t1_valid_e6", ev_valid, 0);
        tick(1);
        check("t1_valid_e7", ev_valid, 1);
        check("t1_idx_e7", ev_idx, 0);
        check("t1_press_e7", ev_press, 1);
        tick(1);
        check("t1_valid_e8", ev_valid, 0);
        b_in = 8'h00;
        expect_ev(1'b0, 0);
        tick(10);
        check("t1_release", b_level, 0);

        // encoded group
        b_in = 8'hA0;
        expect_ev(1'b1, 6);
        tick(10);
        check("enc_code2", b_level, 12'h040);
        b_in = 8'h00;
        expect_ev(1'b0, 6);
        tick(10);
        check("enc_release", b_level, 0);
        b_in = 8'h20;
        tick(10);
        check("enc_msb0", b_level, 0);
        b_in = 8'h00;
        tick(4);

        // bounce shorter than the debounce window
        for (int c = 0; c < 5; c++) begin
            b_in = 8'h01;
            tick(2);
            b_in = 8'h00;
            tick(2);
            check("bounce_level", b_level, 0);
        end
        tick(8);
        check("bounce_final", b_level, 0);

        // backpressure: two presses, register held while not ready
        ev_ready = 1'b0;
        b_in = 8'h03;
        expect_ev(1'b1, 0);
        expect_ev(1'b1, 1);
        tick(7);
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", ev_valid, 1);
            check("hold_idx", ev_idx, 0);
            check("hold_press", ev_press, 1);
            tick(1);
        end
        ev_ready = 1'b1;
        tick(1);
        check("bp_idx1", ev_idx, 1);
        tick(1);
        check("bp_drained", ev_valid, 0);
        b_in = 8'h00;
        expect_ev(1'b0, 0);
        expect_ev(1'b0, 1);
        tick(10);
        check("bp_release", b_level, 0);

        // overflow: second release of bit0 finds its pending bit still set
        ev_ready = 1'b0;
        b_in = 8'h01;
        expect_ev(1'b1, 0);
        tick(8);
        b_in = 8'h00;
        tick(8);
        b_in = 8'h01;
        expect_ev(1'b1, 0);
        tick(8);
        check("ovf_before", overflow, 0);
        b_in = 8'h00;
        expect_ev(1'b0, 0);
        tick(8);
        check("ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        ev_ready = 1'b1;
        tick(5);
        check("ovf_drained", ev_valid, 0);
        check("ovf_level", b_level, 0);

        // reset in the middle of a debounce
        b_in = 8'h01;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_level", b_level, 0);
        check("mid_rst_valid", ev_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_idx", ev_idx, 0);
        check("mid_rst_press", ev_press, 0);
        expect_ev(1'b1, 0);
        tick(5);
        check("mid_rst_e5", b_level, 0);
        tick(1);
        check("mid_rst_e6", b_level, 12'h001);
        tick(1);
        check("mid_rst_ev", ev_valid, 1);
        tick(3);
        b_in = 8'h00;
        expect_ev(1'b0, 0);
        tick(10);

        // final report
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
